// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM pipeline stage plus MEM/WB pipeline register.
// Performs loads/stores against an internal word-addressed array whose
// access takes LATENCY cycles. stall_o freezes the upstream stages while
// an access is in flight. The result is then registered once for WB.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   WB_i[1:0]           WB control (bit0 RegWrite, bit1 MemtoReg)
//   MemRead_i           load request
//   MemWrite_i          store request (has priority over MemRead_i)
//   RegData_i[31:0]     ALU result / byte address
//   MemData_i[31:0]     store data
//   RegAddr_i[4:0]      destination register
//   stall_o             combinational upstream hold
//   WB_o, ReadData_o, ALUData_o, RegAddr_o   MEM/WB register outputs
module mem_wb_stage #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] RegData_i,
  input  logic [31:0] MemData_i,
  input  logic [4:0]  RegAddr_i,
  output logic        stall_o,
  output logic [1:0]  WB_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUData_o,
  output logic [4:0]  RegAddr_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam bit MULTI = (LATENCY > 1);
  localparam logic [CW-1:0] CNT_INIT = MULTI ? CW'(LATENCY - 2) : '0;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Holding registers for the access in flight.
  logic [1:0]      hwb_q, hwb_d;
  logic            hrd_q, hrd_d;
  logic            hwr_q, hwr_d;
  logic [31:0]     haddr_q, haddr_d;
  logic [31:0]     hdata_q, hdata_d;
  logic [4:0]      hra_q, hra_d;

  // MEM/WB register.
  logic [1:0]      wb_q, wb_d;
  logic [31:0]     rd_q, rd_d;
  logic [31:0]     alu_q, alu_d;
  logic [4:0]      ra_q, ra_d;

  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            stall;
  logic            acc_rd;
  logic            acc_wr;
  logic [IW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;

  assign req = MemRead_i | MemWrite_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hwb_d     = hwb_q;
    hrd_d     = hrd_q;
    hwr_d     = hwr_q;
    haddr_d   = haddr_q;
    hdata_d   = hdata_q;
    hra_d     = hra_q;
    wb_d      = '0;
    alu_d     = '0;
    ra_d      = '0;
    stall     = 1'b0;
    acc_rd    = 1'b0;
    acc_wr    = 1'b0;
    acc_idx   = RegData_i[IW+1:2];
    acc_wdata = MemData_i;

    case (state_q)
      IDLE: begin
        if (req && MULTI) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          hwb_d   = WB_i;
          hrd_d   = MemRead_i & ~MemWrite_i;
          hwr_d   = MemWrite_i;
          haddr_d = RegData_i;
          hdata_d = MemData_i;
          hra_d   = RegAddr_i;
        end else begin
          // Non-memory op, or single-cycle access completing at this edge.
          wb_d   = WB_i;
          alu_d  = RegData_i;
          ra_d   = RegAddr_i;
          acc_wr = MemWrite_i;
          acc_rd = MemRead_i & ~MemWrite_i;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Completion: stall drops so upstream advances on this same edge.
          state_d   = IDLE;
          wb_d      = hwb_q;
          alu_d     = haddr_q;
          ra_d      = hra_q;
          acc_wr    = hwr_q;
          acc_rd    = hrd_q;
          acc_idx   = haddr_q[IW+1:2];
          acc_wdata = hdata_q;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_d = acc_rd ? mem_q[acc_idx] : '0;
  end

  assign stall_o = stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hwb_q   <= '0;
      hrd_q   <= 1'b0;
      hwr_q   <= 1'b0;
      haddr_q <= '0;
      hdata_q <= '0;
      hra_q   <= '0;
      wb_q    <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hwb_q   <= hwb_d;
      hrd_q   <= hrd_d;
      hwr_q   <= hwr_d;
      haddr_q <= haddr_d;
      hdata_q <= hdata_d;
      hra_q   <= hra_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      ra_q    <= ra_d;
    end
  end

  // Array is not reset; a reset edge suppresses any write so an aborted
  // store leaves the contents untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_wr) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign WB_o       = wb_q;
  assign ReadData_o = rd_q;
  assign ALUData_o  = alu_q;
  assign RegAddr_o  = ra_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned LATENCY = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  WB_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] RegData_i;
  logic [31:0] MemData_i;
  logic [4:0]  RegAddr_i;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] ReadData_o;
  logic [31:0] ALUData_o;
  logic [4:0]  RegAddr_o;

  mem_wb_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .WB_i       (WB_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .RegData_i  (RegData_i),
    .MemData_i  (MemData_i),
    .RegAddr_i  (RegAddr_i),
    .stall_o    (stall_o),
    .WB_o       (WB_o),
    .ReadData_o (ReadData_o),
    .ALUData_o  (ALUData_o),
    .RegAddr_o  (RegAddr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  ra;
  } res_t;

  res_t sb[$];
  int tests  = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples stall/reset on the falling edge, then checks the
  // MEM/WB register just after the following rising edge.
  initial begin
    logic s_stall, s_rst;
    res_t e;
    forever begin
      @(negedge clk_i);
      s_stall = stall_o;
      s_rst   = rst_i;
      @(posedge clk_i);
      #1;
      if (s_rst) begin
        check("rst_WB",    {30'd0, WB_o},      32'd0);
        check("rst_RD",    ReadData_o,         32'd0);
        check("rst_ALU",   ALUData_o,          32'd0);
        check("rst_RA",    {27'd0, RegAddr_o}, 32'd0);
      end else if (s_stall) begin
        check("bubble_WB", {30'd0, WB_o},      32'd0);
        check("bubble_RA", {27'd0, RegAddr_o}, 32'd0);
      end else if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got WB=%b ALU=%h with no expected result", WB_o, ALUData_o);
      end else begin
        e = sb.pop_front();
        check("res_WB",  {30'd0, WB_o},      {30'd0, e.wb});
        check("res_RD",  ReadData_o,         e.rd);
        check("res_ALU", ALUData_o,          e.alu);
        check("res_RA",  {27'd0, RegAddr_o}, {27'd0, e.ra});
      end
    end
  end

  task automatic drive(input logic [1:0] wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra);
    WB_i = wb; MemRead_i = r; MemWrite_i = w;
    RegData_i = a; MemData_i = d; RegAddr_i = ra;
  endtask

  // Issue one op, push its expected result, wait (bounded) until it completes.
  task automatic issue(input logic [1:0] wb, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] ra,
                       input logic [31:0] exp_rd, input int exp_stall);
    int  nst;
    bit  done;
    res_t e;
    drive(wb, r, w, a, d, ra);
    e.wb = wb; e.rd = exp_rd; e.alu = a; e.ra = ra;
    sb.push_back(e);
    nst  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_i);
      if (stall_o) nst++;
      else done = 1'b1;
      @(posedge clk_i);
      #2;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: op at addr %h never completed, stall cycles %0d required %0d", a, nst, exp_stall);
    end else begin
      check("stall_cycles", nst, exp_stall);
    end
  endtask

  task automatic idle_cycle();
    issue(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 0);
  endtask

  localparam int ML = LATENCY - 1;

  initial begin
    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    check("rst_stall", {31'd0, stall_o}, 32'd0);

    // ALU pass-through
    issue(2'b01, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 32'd0, 0);
    issue(2'b10, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 5'd31, 32'd0, 0);

    // Reset mid-stream with a non-memory op on the inputs
    drive(2'b11, 1'b0, 1'b0, 32'h5555_AAAA, 32'h0, 5'd9);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    #1;
    rst_i = 1'b0;
    idle_cycle();

    // Store (WB=00) then immediately load same word
    issue(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 32'd0, ML);
    issue(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 32'hDEAD_BEEF, ML);

    // Wrap / alignment: 0x84 and 0x07 both map to word 1
    issue(2'b00, 1'b0, 1'b1, 32'h84, 32'hA5, 5'd0, 32'd0, ML);
    issue(2'b11, 1'b1, 1'b0, 32'h07, 32'h0, 5'd6, 32'hA5, ML);

    // Both read and write: store wins, ReadData 0
    issue(2'b01, 1'b1, 1'b1, 32'h08, 32'h55, 5'd3, 32'd0, ML);
    issue(2'b11, 1'b1, 1'b0, 32'h08, 32'h0, 5'd4, 32'h55, ML);
    idle_cycle();

    // Prior value at 0x20, then aborted store of 0x99
    issue(2'b00, 1'b0, 1'b1, 32'h20, 32'h11, 5'd0, 32'd0, ML);
    drive(2'b01, 1'b0, 1'b1, 32'h20, 32'h99, 5'd2);
    @(negedge clk_i);
    check("abort_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i);
    #2;
    drive(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("abort_rst_stall", {31'd0, stall_o}, 32'd0);
    #1;
    rst_i = 1'b0;
    idle_cycle();
    issue(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd8, 32'h11, ML);

    // Pass-through right after a memory op completes
    issue(2'b01, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, 5'd12, 32'd0, 0);
    idle_cycle();
    idle_cycle();

    @(negedge clk_i);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
